// File: rtl/dual_slope_seq.sv
// Dual-slope voltmeter conversion sequencer: auto-zero, fixed 1000-count integrate,
// comparator-terminated de-integrate, then latch of the 000..999 BCD count.
module dual_slope_seq #(
    parameter int AZ_CYCLES = 1000,
    parameter int AZW       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       abort,
    input  logic       comp,
    output logic       ch_zr,
    output logic       ch_vm,
    output logic       ch_ref,
    output logic       busy,
    output logic       valid,
    output logic       ovr,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_AZ,
        S_INT,
        S_DEINT,
        S_LATCH
    } state_t;

    state_t         r_state;
    logic [AZW-1:0] r_azCnt;
    logic [3:0]     r_cnt2, r_cnt1, r_cnt0;
    logic           r_compMeta, r_compS;
    logic           r_chZr, r_chVm, r_chRef, r_busy, r_valid, r_ovr;
    logic [3:0]     r_dig2, r_dig1, r_dig0;

    state_t         w_next;
    logic           w_cntEn, w_cntClr, w_latchOvr;
    logic           w_cnt999, w_azDone;
    logic [3:0]     w_inc2, w_inc1, w_inc0;

    assign w_cnt999 = (r_cnt2 == 4'd9) && (r_cnt1 == 4'd9) && (r_cnt0 == 4'd9);
    assign w_azDone = (r_azCnt == AZW'(AZ_CYCLES - 1));

    // Decade chain: units always step, carry ripples only on a 9 -> 0 rollover.
    always_comb begin
        w_inc0 = (r_cnt0 == 4'd9) ? 4'd0 : r_cnt0 + 4'd1;
        w_inc1 = r_cnt1;
        w_inc2 = r_cnt2;
        if (r_cnt0 == 4'd9) begin
            w_inc1 = (r_cnt1 == 4'd9) ? 4'd0 : r_cnt1 + 4'd1;
            if (r_cnt1 == 4'd9) begin
                w_inc2 = (r_cnt2 == 4'd9) ? 4'd0 : r_cnt2 + 4'd1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cntEn    = 1'b0;
        w_cntClr   = 1'b0;
        w_latchOvr = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cntClr = 1'b1;
                if (run) w_next = S_AZ;
            end
            S_AZ: begin
                if (w_azDone) w_next = S_INT;
            end
            S_INT: begin
                w_cntEn = 1'b1;
                if (w_cnt999) w_next = S_DEINT;
            end
            S_DEINT: begin
                if (r_compS) begin
                    w_next = S_LATCH;
                end else if (w_cnt999) begin
                    w_next     = S_LATCH;
                    w_latchOvr = 1'b1;
                end else begin
                    w_cntEn = 1'b1;
                end
            end
            S_LATCH: begin
                w_cntClr = 1'b1;
                w_next   = run ? S_AZ : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next   = S_IDLE;
            w_cntEn  = 1'b0;
            w_cntClr = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with r_state without glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_azCnt    <= '0;
            r_cnt2     <= 4'd0;
            r_cnt1     <= 4'd0;
            r_cnt0     <= 4'd0;
            r_compMeta <= 1'b0;
            r_compS    <= 1'b0;
            r_chZr     <= 1'b1;
            r_chVm     <= 1'b0;
            r_chRef    <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
            r_dig2     <= 4'd0;
            r_dig1     <= 4'd0;
            r_dig0     <= 4'd0;
        end else begin
            r_compMeta <= comp;
            r_compS    <= r_compMeta;
            r_state    <= w_next;
            r_azCnt    <= (r_state == S_AZ && !w_azDone && !abort) ? r_azCnt + AZW'(1) : '0;
            if (w_cntClr) begin
                r_cnt2 <= 4'd0;
                r_cnt1 <= 4'd0;
                r_cnt0 <= 4'd0;
            end else if (w_cntEn) begin
                r_cnt2 <= w_inc2;
                r_cnt1 <= w_inc1;
                r_cnt0 <= w_inc0;
            end
            r_chZr  <= (w_next == S_IDLE) || (w_next == S_AZ) || (w_next == S_LATCH);
            r_chVm  <= (w_next == S_INT);
            r_chRef <= (w_next == S_DEINT);
            r_busy  <= (w_next != S_IDLE);
            r_valid <= (w_next == S_LATCH);
            if (w_next == S_LATCH) begin
                r_dig2 <= r_cnt2;
                r_dig1 <= r_cnt1;
                r_dig0 <= r_cnt0;
                r_ovr  <= w_latchOvr;
            end
        end
    end

    assign ch_zr  = r_chZr;
    assign ch_vm  = r_chVm;
    assign ch_ref = r_chRef;
    assign busy   = r_busy;
    assign valid  = r_valid;
    assign ovr    = r_ovr;
    assign dig2   = r_dig2;
    assign dig1   = r_dig1;
    assign dig0   = r_dig0;

endmodule

// File: doc/dual_slope_seq.md
Name: dual_slope_seq

Overview:
Conversion sequencer for the team's 3-digit dual-slope voltmeter. It drives the one-hot analog switch controls (ch_zr, ch_vm, ch_ref) through auto-zero, fixed integrate and de-integrate phases. It owns its internal 000..999 BCD count chain and latches the de-integrate count into held display digits on comparator zero-crossing. It sits between the comparator input and the 7-segment decoder/display registers, replacing free-running phase stepping with a measured, comparator-terminated conversion.

Parameters:
AZ_CYCLES, 1000, number of clock cycles spent in auto-zero (range 1..65535)
AZW, 16, width of the auto-zero cycle counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
run  input  1  level; 1 = convert continuously, 0 = stop after current conversion
abort  input  1  synchronous; 1 = drop the conversion, go to IDLE next cycle
comp  input  1  asynchronous integrator-zero comparator (1 = crossed zero)
ch_zr  output  1  auto-zero switch
ch_vm  output  1  input (Vm) integrate switch
ch_ref  output  1  reference de-integrate switch
busy  output  1  1 in any state other than IDLE
valid  output  1  one-cycle pulse when dig2..dig0/ovr are updated
ovr  output  1  overrange flag of the last result
dig2  output  4  held BCD hundreds digit
dig1  output  4  held BCD tens digit
dig0  output  4  held BCD units digit

Behaviour:
- rst=0 (async): state IDLE, BCD count 000, AZ counter 0, sync flops 0; ch_zr=1, ch_vm=0, ch_ref=0, busy=0, valid=0, ovr=0, dig2..dig0=0.
- comp passes through a 2-flop synchronizer; comp_s is its output. Only comp_s is used, so comp_s lags comp by 2 clocks.
- BCD chain: 3 cascaded decade digits. Units increment when cnt_en is set; a carry ripples on 9->0; 999 wraps to 000. Every digit stays 0..9.
- Switch outputs are registered and decoded from the state register only, so they are one-hot and glitch-free.
- States:
  - IDLE: ch_zr=1. Count is held at 000. Goes to AZ when run=1.
  - AZ: ch_zr=1. The AZ counter counts from 0. After exactly AZ_CYCLES cycles in AZ, goes to INT with AZ counter cleared.
  - INT: ch_vm=1, cnt_en=1. The count runs 000..999. In the cycle where the count is 999, goes to DEINT and the count wraps to 000. INT therefore lasts exactly 1000 cycles.
  - DEINT: ch_ref=1. Each cycle the count is N:
    - If comp_s=1, go to LATCH with the count frozen at N.
    - Otherwise, if N=999, go to LATCH with the count frozen at 999 and overrange flagged.
    - Otherwise, increment.
    - comp_s=1 takes priority over N=999. DEINT lasts N+1 cycles.
  - LATCH: one cycle, ch_zr=1.
    - dig2..dig0 take the frozen count.
    - ovr is set to the overrange flag.
    - valid=1 for this cycle only.
    - The count clears to 000.
    - Next state is AZ if run=1, else IDLE.
- comp_s=1 already on the first DEINT cycle gives result 000, ovr=0.
- comp_s is ignored outside DEINT.
- run falling mid-conversion: the conversion completes normally, then the block goes to IDLE.
- abort=1 in any state: next state is IDLE; count and AZ counter clear; no valid pulse; dig/ovr keep their previous values. abort takes priority over all transitions.
- Asserting rst mid-operation forces the reset values immediately, with no valid pulse.
- Held digits change only in LATCH.

Test Plan:
- Reset then idle: rst=0 then 1, run=0 for 50 cycles -> ch_zr=1, ch_vm=ch_ref=0, busy=0, valid=0, dig=0,0,0, ovr=0.
- Nominal conversion, AZ_CYCLES=8: run=1; drive comp so that comp_s first reads 1 when the DEINT count is 437 -> ch_zr high 8 cycles (AZ), ch_vm high exactly 1000, ch_ref high 438. valid pulses once with dig2=4, dig1=3, dig0=7, ovr=0. The next AZ follows immediately.
- Overrange: comp held 0 throughout -> ch_ref high 1000 cycles, dig=9,9,9, ovr=1. The next conversion, with a crossing at 012, gives dig=0,1,2 and ovr=0.
- Zero input: comp=1 from mid-INT onward -> DEINT lasts 1 cycle, dig=0,0,0, ovr=0.
- run dropped during INT: the conversion finishes with a valid pulse, then IDLE (busy=0, ch_zr=1), and no further AZ.
- abort during DEINT at count 250, and separately rst pulsed low in INT -> IDLE next cycle (abort) or immediately (rst); no valid pulse. After abort the digits keep the prior result; after rst they read 0,0,0.
